// File: rtl/mux64_scan_ctrl.sv
// Round-robin scan sequencer for the mux64x1 bit-select datapath with a valid/ready sample port.
// Optional CHANGE_ONLY_EN: suppress a capture whose value matches the last one seen on that channel.
module mux64_scan_ctrl #(
  parameter int NUM_CH     = 64,
  parameter int SEL_W      = 6,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scan_en_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  output logic [SEL_W-1:0]  mux_sel_o,
  input  logic              mux_out_i,
  output logic              smp_valid_o,
  input  logic              smp_ready_i,
  output logic              smp_data_o,
  output logic [SEL_W-1:0]  smp_ch_o,
  output logic              busy_o,
  output logic              scan_wrap_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  localparam logic [3:0]       CNT_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] PTR_RST  = SEL_W'(NUM_CH - 1);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("mux64_scan_ctrl: SETTLE_CYC must be in 1..15");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             wrap_q, wrap_d;
  logic             first_q, first_d;

  logic [SEL_W-1:0] next_ch;
  logic             any_en;
  logic             start;
  logic             load;
  logic             emit;

`ifdef CHANGE_ONLY_EN
  logic [NUM_CH-1:0] last_q, last_d;
  logic [NUM_CH-1:0] seen_q, seen_d;
`endif

  assign any_en = |ch_en_i;
  assign start  = scan_en_i && any_en;

  // Walk offsets downward so the nearest enabled channel after ptr wins; offset NUM_CH is ptr itself.
  always_comb begin
    next_ch = ptr_q;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (ch_en_i[ptr_q + SEL_W'(i)]) begin
        next_ch = ptr_q + SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    wrap_d  = 1'b0;
    first_d = first_q;
    load    = 1'b0;
    emit    = 1'b1;
`ifdef CHANGE_ONLY_EN
    last_d  = last_q;
    seen_d  = seen_q;
`endif

    unique case (state_q)
      IDLE: begin
        load = start;
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
`ifdef CHANGE_ONLY_EN
          emit          = !(seen_q[sel_q] && (last_q[sel_q] == mux_out_i));
          last_d[sel_q] = mux_out_i;
          seen_d[sel_q] = 1'b1;
`endif
          if (emit) begin
            data_d  = mux_out_i;
            ch_d    = sel_q;
            valid_d = 1'b1;
            state_d = OUTPUT;
          end else if (start) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      OUTPUT: begin
        if (smp_ready_i) begin
          valid_d = 1'b0;
          if (start) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A channel load is the only place the select moves, so it stays put through SETTLE/OUTPUT.
    if (load) begin
      state_d = SETTLE;
      ptr_d   = next_ch;
      sel_d   = next_ch;
      cnt_d   = 4'd0;
      wrap_d  = !first_q && (next_ch <= ptr_q);
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      sel_q   <= '0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      data_q  <= 1'b0;
      ch_q    <= '0;
      wrap_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      wrap_q  <= wrap_d;
      first_q <= first_d;
    end
  end

`ifdef CHANGE_ONLY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= '0;
      seen_q <= '0;
    end else begin
      last_q <= last_d;
      seen_q <= seen_d;
    end
  end
`endif

  assign mux_sel_o   = sel_q;
  assign smp_valid_o = valid_q;
  assign smp_data_o  = data_q;
  assign smp_ch_o    = ch_q;
  assign busy_o      = (state_q != IDLE);
  assign scan_wrap_o = wrap_q;

  a_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    smp_valid_o && !smp_ready_i |=> smp_valid_o && $stable(smp_data_o) && $stable(smp_ch_o));

  a_sel_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    !load |=> $stable(sel_q));

endmodule

// File: tb/tb_mux64_scan_ctrl.sv
// Self-checking bench for mux64_scan_ctrl: a table of scan patterns driven through a scoreboard,
// plus hand-built sequences for backpressure, scan_en drop, reset in OUTPUT and change-only capture.
module tb_mux64_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        scanEn;
  logic        ready;
  logic        muxOut;
  logic [63:0] chEn;
  logic [63:0] muxIn;
  logic [5:0]  muxSel;
  logic [5:0]  smpCh;
  logic        smpValid;
  logic        smpData;
  logic        busy;
  logic        scanWrap;

  always #5 clk = ~clk;

  // Behavioural stand-in for mux64x1.
  assign muxOut = muxIn[muxSel];

  mux64_scan_ctrl #(.NUM_CH(64), .SEL_W(6), .SETTLE_CYC(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .scan_en_i   (scanEn),
    .ch_en_i     (chEn),
    .mux_sel_o   (muxSel),
    .mux_out_i   (muxOut),
    .smp_valid_o (smpValid),
    .smp_ready_i (ready),
    .smp_data_o  (smpData),
    .smp_ch_o    (smpCh),
    .busy_o      (busy),
    .scan_wrap_o (scanWrap)
  );

  typedef struct packed {
    logic [5:0] ch;
    logic       data;
  } exp_t;

  typedef struct {
    logic [63:0] en;
    logic [63:0] din;
    int          n;
    int          nwrap;
  } vec_t;

  exp_t expQ[$];
  int   hsLog[$];
  int   checks    = 0;
  int   errors    = 0;
  int   popCount  = 0;
  int   wrapCount = 0;
  int   cycle     = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [5:0] ch, input logic data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Scoreboard: every handshake must match the oldest expected sample.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && smpValid && ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_extra: got ch %0d data %0d, want no sample", smpCh, smpData);
      end else begin
        e = expQ.pop_front();
        checkOutput("smp_ch", {58'd0, smpCh}, {58'd0, e.ch});
        checkOutput("smp_data", {63'd0, smpData}, {63'd0, e.data});
      end
      popCount++;
      hsLog.push_back(cycle);
    end
    if (!rst && scanWrap) wrapCount++;
  end

  // Reference channel order: first enabled index above p, else the lowest enabled index up to p.
  function automatic logic [5:0] refNext(input logic [5:0] p, input logic [63:0] en);
    logic [5:0] r;
    bit         hit;
    r   = p;
    hit = 1'b0;
    for (int j = 0; j < 64; j++) begin
      if (!hit && en[j] && (j > int'(p))) begin
        r   = j[5:0];
        hit = 1'b1;
      end
    end
    for (int j = 0; j < 64; j++) begin
      if (!hit && en[j] && (j <= int'(p))) begin
        r   = j[5:0];
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic applyReset();
    rst    = 1'b1;
    scanEn = 1'b0;
    ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expQ.delete();
  endtask

  task automatic applyStimulus(input logic [63:0] en, input logic [63:0] din);
    chEn  = en;
    muxIn = din;
  endtask

  // Wait for popCount to reach target; optionally drop scan_en before the final handshake edge.
  task automatic waitPops(input int target, input int budget, input bit stop);
    int n = 0;
    while (popCount < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (stop) scanEn = 1'b0;
    checkOutput("pop_count", 64'(popCount), 64'(target));
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    checkOutput("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!smpValid && n < budget);
    checkOutput("valid_seen", {63'd0, smpValid}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs[5];
    vec_t       cur;
    logic [5:0] p;
    int         base;
    int         startCycle;
    int         busyCnt;
    int         validCnt;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 65, 1};
    vecs[1] = '{64'h8000_0000_0000_0011, 64'h8000_0000_0000_0010, 5, 1};
    vecs[2] = '{64'h0000_0000_0000_0200, 64'h0000_0000_0000_0200, 3, 2};
    vecs[3] = '{64'h0000_0F00_0000_0000, 64'h0123_4567_89AB_CDEF, 6, 1};
    vecs[4] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 4, 1};

    applyStimulus(64'd0, 64'd0);
    applyReset();
    checkOutput("rst_mux_sel", {58'd0, muxSel}, 64'd0);
    checkOutput("rst_valid", {63'd0, smpValid}, 64'd0);
    checkOutput("rst_data", {63'd0, smpData}, 64'd0);
    checkOutput("rst_ch", {58'd0, smpCh}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_wrap", {63'd0, scanWrap}, 64'd0);

    // All-zero enable: scan_en alone must not start anything.
    scanEn   = 1'b1;
    busyCnt  = 0;
    validCnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (smpValid) validCnt++;
    end
    checkOutput("zero_en_busy", 64'(busyCnt), 64'd0);
    checkOutput("zero_en_valid", 64'(validCnt), 64'd0);
    scanEn = 1'b0;

`ifndef CHANGE_ONLY_EN
    for (int v = 0; v < 5; v++) begin
      cur = vecs[v];
      applyReset();
      applyStimulus(cur.en, cur.din);
      p = 6'd63;
      for (int k = 0; k < cur.n; k++) begin
        p = refNext(p, cur.en);
        pushExp(p, cur.din[p]);
      end
      wrapCount = 0;
      hsLog.delete();
      base = popCount;
      @(posedge clk);
      #1;
      startCycle = cycle;
      scanEn     = 1'b1;
      waitPops(base + cur.n, cur.n * 3 + 20, 1'b1);
      waitIdle(20);
      checkOutput($sformatf("v%0d_wrap", v), 64'(wrapCount), 64'(cur.nwrap));
      checkOutput($sformatf("v%0d_sb_left", v), 64'(expQ.size()), 64'd0);
      if (hsLog.size() > 0) begin
        checkOutput($sformatf("v%0d_latency", v), 64'(hsLog[0] - startCycle), 64'd3);
        checkOutput($sformatf("v%0d_spacing", v), 64'(hsLog[hsLog.size()-1] - hsLog[0]),
                    64'((cur.n - 1) * 3));
      end
    end
`endif

    // Backpressure on ch 5, then ch_en cleared at the releasing handshake.
    applyReset();
    applyStimulus(64'h68, 64'h20);
    pushExp(6'd3, 1'b0);
    pushExp(6'd5, 1'b1);
    base = popCount;
    @(posedge clk);
    #1 scanEn = 1'b1;
    waitPops(base + 1, 20, 1'b0);
    @(posedge clk);
    #1 ready = 1'b0;
    waitValid(20);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("bp_hold%0d", k), {50'd0, smpValid, smpData, smpCh, muxSel},
                  {50'd0, 1'b1, 1'b1, 6'd5, 6'd5});
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ready = 1'b1;
    chEn  = 64'd0;
    waitPops(base + 2, 5, 1'b0);
    waitIdle(10);
    repeat (6) @(negedge clk);
    checkOutput("bp_accept_once", 64'(popCount - base), 64'd2);
    checkOutput("bp_valid_low", {63'd0, smpValid}, 64'd0);
    scanEn = 1'b0;

    // scan_en dropped during SETTLE of ch 7; restart resumes at ch 8.
    applyReset();
    applyStimulus(64'h380, 64'h100);
    pushExp(6'd7, 1'b0);
    base = popCount;
    @(posedge clk);
    #1 scanEn = 1'b1;
    @(posedge clk);
    #1 scanEn = 1'b0;
    waitPops(base + 1, 20, 1'b0);
    waitIdle(10);
    repeat (3) @(negedge clk);
    checkOutput("drop_busy", {63'd0, busy}, 64'd0);
    checkOutput("drop_valid", {63'd0, smpValid}, 64'd0);
    checkOutput("drop_sel_hold", {58'd0, muxSel}, 64'd7);
    pushExp(6'd8, 1'b1);
    @(posedge clk);
    #1 scanEn = 1'b1;
    waitPops(base + 2, 20, 1'b1);
    waitIdle(20);

    // Reset while a sample is pending; restart begins again at the lowest enabled channel.
    applyReset();
    applyStimulus(64'h0010_0404, 64'h400);
    pushExp(6'd2, 1'b0);
    base = popCount;
    @(posedge clk);
    #1 scanEn = 1'b1;
    waitPops(base + 1, 20, 1'b0);
    @(posedge clk);
    #1 ready = 1'b0;
    waitValid(20);
    checkOutput("rstout_pre_ch", {58'd0, smpCh}, 64'd10);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    scanEn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstout_state", {48'd0, muxSel, smpValid, smpData, smpCh, busy, scanWrap}, 64'd0);
    rst   = 1'b0;
    ready = 1'b1;
    expQ.delete();
    pushExp(6'd2, 1'b0);
    wrapCount = 0;
    base      = popCount;
    @(posedge clk);
    #1 scanEn = 1'b1;
    waitPops(base + 1, 20, 1'b1);
    waitIdle(20);
    checkOutput("rstout_no_wrap", 64'(wrapCount), 64'd0);

    // Single enabled channel with a constant input.
    applyReset();
    applyStimulus(64'h8, 64'h8);
    base = popCount;
`ifdef CHANGE_ONLY_EN
    pushExp(6'd3, 1'b1);
    @(posedge clk);
    #1 scanEn = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("co_first", 64'(popCount - base), 64'd1);
    pushExp(6'd3, 1'b0);
    @(posedge clk);
    #1 muxIn = 64'd0;
    repeat (40) @(negedge clk);
    checkOutput("co_toggle", 64'(popCount - base), 64'd2);
    #1 scanEn = 1'b0;
    waitIdle(20);
`else
    for (int k = 0; k < 3; k++) pushExp(6'd3, 1'b1);
    @(posedge clk);
    #1 scanEn = 1'b1;
    waitPops(base + 3, 30, 1'b1);
    waitIdle(20);
`endif
    checkOutput("single_sb_left", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
